unit_slave_responder: RTL and testbench
=======================================

Name: unit_slave_responder

Overview:
- Synthesizable responder bank that models the 6 downstream slaves on the output side of the unit address decoder.
- Consumes the decoder's select, direction, address and write-data outputs.
- Returns an ack pulse and read data after a fixed wait-state count.
- Used as the slave-side counterpart in integration benches and as a drop-in stub at top level.

Parameters:
- NUM_SLAVES, 6, number of select lines and slave memories.
- DATA_W, 8, data width.
- ADDR_W, 8, address width; only the low log2(MEM_DEPTH) bits index memory.
- MEM_DEPTH, 16, words per slave memory.
- WAIT_CYCLES, 2, wait states between select capture and ack (0..15).

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous active-high reset.
- sel_en_out  in  NUM_SLAVES  one-hot slave select from the decoder.
- wr_rd_d_out  in  1  1 = write, 0 = read.
- addr_out  in  ADDR_W  slave address.
- wr_data_out  in  DATA_W  write data.
- rd_data_in  out  DATA_W  read data back to the decoder.
- ack_in  out  NUM_SLAVES  per-slave ack, one-cycle pulse.

Behaviour:
- Reset (synchronous, active-high):
  - ack_in = 0, rd_data_in = 0, FSM = IDLE, wait counter = 0.
  - Every word is initialised: mem[s][a] = (s << 4) | a, truncated to DATA_W.
  - Reset asserted mid-transaction aborts it: no ack, no write.
- FSM states:
  - IDLE
    - Exactly one bit of sel_en_out set: latch slave index, wr_rd_d_out, addr_out[3:0] and wr_data_out.
    - Load counter = WAIT_CYCLES.
    - Go to WAIT if WAIT_CYCLES > 0, else go to ACK.
    - Zero bits or more than one bit set: stay in IDLE, no response.
  - WAIT
    - Decrement counter each cycle; at 1, go to ACK next.
    - Latched slave's sel bit drops, or a different slave's bit rises: abort to IDLE, no ack, no write.
  - ACK, for one cycle:
    - ack_in[idx] = 1.
    - Read: rd_data_in = mem[idx][addr].
    - Write: mem[idx][addr] <= latched data; rd_data_in = 0.
    - Then go to HOLD.
  - HOLD
    - ack_in = 0; rd_data_in keeps its last value.
    - Return to IDLE once sel_en_out == 0.
    - A select that stays asserted after ack never starts a second transaction.
- Latency: select capture to ack = WAIT_CYCLES + 1 clocks.
  - WAIT_CYCLES = 0: ack appears on the cycle after capture.
- Write data and address are sampled only at capture; later changes on those inputs are ignored.
- Addresses at or beyond MEM_DEPTH wrap modulo MEM_DEPTH (upper bits ignored).
- ack_in is always zero-hot or one-hot.
- rd_data_in changes only in ACK cycles or on reset.

Optional Feature:
- RESP_PROTO_CHECK_EN
- Defined:
  - Adds output port proto_err (1 bit, sticky, reset to 0).
  - proto_err sets on a multi-hot sel_en_out in IDLE.
  - proto_err sets on a select abort in WAIT.
  - proto_err sets when wr_rd_d_out, addr_out or wr_data_out change while sel is held during WAIT.
  - Cleared only by reset.
- Undefined: no port, no checking logic; FSM behaviour is identical.

Decomposition:
- Package slave_resp_pack holds:
  - state enum {IDLE, WAIT, ACK, HOLD}.
  - Default constants NUM_SLAVES, DATA_W, ADDR_W, MEM_DEPTH.
  - Function onehot_idx (returns the index and a valid flag).
- Sub-module slave_mem: single-port, one synchronous write and one combinational read.
  - One instance per slave via generate.
  - Init pattern applied on reset.
- The top module holds the FSM, counter and output registers.

Test Plan:
- Read, WAIT_CYCLES=2:
  - Stimulus: sel_en_out=6'b000100, wr_rd_d_out=0, addr_out=8'h05, held.
  - Required: ack_in=6'b000100 exactly 3 clocks after capture, for 1 cycle; rd_data_in=8'h25.
- Write then read back:
  - Stimulus: sel=6'b000001, write addr 8'h0A, data 8'hC3; release sel; read the same address.
  - Required: second ack carries rd_data_in=8'hC3; slave 0 addr 8'h1A also returns 8'hC3 (wrap).
- Abort:
  - Stimulus: sel=6'b100000 read, dropped after 1 cycle of WAIT.
  - Required: no ack ever, memory unchanged, FSM back to IDLE; with RESP_PROTO_CHECK_EN, proto_err=1.
- Multi-hot:
  - Stimulus: sel=6'b000011 held 10 cycles.
  - Required: ack_in stays 0; with RESP_PROTO_CHECK_EN, proto_err=1 and remains 1 until reset.
- Hold and WAIT_CYCLES=0:
  - Stimulus: sel=6'b010000 held 8 cycles, read addr 8'h03.
  - Required: a single ack 1 clock after capture, rd_data_in=8'h43; no second ack until sel returns to 0 and is reasserted.
- Reset mid-transaction:
  - Stimulus: assert reset during WAIT of a write to slave 1, addr 8'h02, data 8'hFF.
  - Required: next cycle ack_in=0, rd_data_in=0; a subsequent read returns 8'h12.

Source files
------------

// File: rtl/unit_slave_responder_pkg.sv
// Shared types, default sizes and the one-hot decode helper for the slave
// responder bank.
//   state_t      : responder FSM states
//   onehot_t     : result of onehot_idx (valid flag + bit index)
//   onehot_idx() : index of the single set bit of a select vector; valid
//                  only when exactly one bit is set (up to MAX_SEL lines)
package slave_resp_pack;

    localparam int DEF_NUM_SLAVES  = 6;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_MEM_DEPTH   = 16;
    localparam int DEF_WAIT_CYCLES = 2;

    // Widest select vector onehot_idx accepts; narrower vectors are
    // zero-extended by the caller.
    localparam int MAX_SEL   = 32;
    localparam int SEL_IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        HOLD
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [SEL_IDX_W-1:0] idx;
    } onehot_t;

    function automatic onehot_t onehot_idx(input logic [MAX_SEL-1:0] sel);
        onehot_t r;
        int      hits;
        r    = '0;
        hits = 0;
        for (int i = 0; i < MAX_SEL; i++) begin
            if (sel[i]) begin
                r.idx = SEL_IDX_W'(i);
                hits++;
            end
        end
        r.valid = (hits == 1);
        return r;
    endfunction

endpackage

// File: rtl/unit_slave_responder_if.sv
// Decoder <-> slave bank bus.
//   master modport : the address decoder (drives select/dir/addr/wdata,
//                    receives read data and per-slave ack)
//   slave  modport : the responder bank
interface unit_slave_responder_if #(
    parameter int NUM_SLAVES = slave_resp_pack::DEF_NUM_SLAVES,
    parameter int DATA_W     = slave_resp_pack::DEF_DATA_W,
    parameter int ADDR_W     = slave_resp_pack::DEF_ADDR_W
) ();
    import slave_resp_pack::*;

    logic [NUM_SLAVES-1:0] sel_en_out;
    logic                  wr_rd_d_out;   // 1 = write, 0 = read
    logic [ADDR_W-1:0]     addr_out;
    logic [DATA_W-1:0]     wr_data_out;
    logic [DATA_W-1:0]     rd_data_in;
    logic [NUM_SLAVES-1:0] ack_in;

    modport master (
        output sel_en_out, wr_rd_d_out, addr_out, wr_data_out,
        input  rd_data_in, ack_in
    );

    modport slave (
        input  sel_en_out, wr_rd_d_out, addr_out, wr_data_out,
        output rd_data_in, ack_in
    );

endinterface

// File: rtl/unit_slave_responder_mem.sv
// One slave's word memory: synchronous write, combinational read, single
// shared address. Reset loads word a with (SLAVE_ID << 4) | a.
//   clock, reset : posedge clock, synchronous active-high reset
//   we           : write enable
//   addr         : word address (already wrapped to the memory depth)
//   wdata        : write data
//   rdata        : read data at addr
module slave_mem #(
    parameter int DATA_W    = slave_resp_pack::DEF_DATA_W,
    parameter int MEM_DEPTH = slave_resp_pack::DEF_MEM_DEPTH,
    parameter int AW        = $clog2(MEM_DEPTH),
    parameter int SLAVE_ID  = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    import slave_resp_pack::*;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int a = 0; a < MEM_DEPTH; a++) begin
                mem[a] <= DATA_W'((SLAVE_ID << 4) | a);
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/unit_slave_responder.sv
// Responder bank standing in for the slaves behind the unit address decoder.
// A one-hot select seen in IDLE is captured together with direction, wrapped
// address and write data; after WAIT_CYCLES wait states the ACK state
// performs the access and the next edge raises a one-cycle ack (capture to
// ack = WAIT_CYCLES + 1 clocks). The responder then sits in HOLD until the
// select is released, so a held select never retriggers.
//   clock, reset : posedge clock, synchronous active-high reset
//   bus          : slave side of unit_slave_responder_if
//   proto_err    : only with RESP_PROTO_CHECK_EN defined; sticky flag for
//                  multi-hot select, select abort, or bus fields changing
//                  while a select is held in WAIT
module unit_slave_responder #(
    parameter int NUM_SLAVES  = slave_resp_pack::DEF_NUM_SLAVES,
    parameter int DATA_W      = slave_resp_pack::DEF_DATA_W,
    parameter int ADDR_W      = slave_resp_pack::DEF_ADDR_W,
    parameter int MEM_DEPTH   = slave_resp_pack::DEF_MEM_DEPTH,
    parameter int WAIT_CYCLES = slave_resp_pack::DEF_WAIT_CYCLES
) (
    input  logic clock,
    input  logic reset,
`ifdef RESP_PROTO_CHECK_EN
    output logic proto_err,
`endif
    unit_slave_responder_if.slave bus
);
    import slave_resp_pack::*;

    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W  = 4;

    state_t                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic                             wr_q, wr_d;
    logic [MEM_AW-1:0]                addr_q, addr_d;
    logic [DATA_W-1:0]                data_q, data_d;
    logic [NUM_SLAVES-1:0]            ack_q, ack_d;
    logic [DATA_W-1:0]                rd_q, rd_d;

    logic [MAX_SEL-1:0]               sel_ext;
    onehot_t                          oh;
    logic [NUM_SLAVES-1:0]            own_mask;
    logic                             sel_abort;
    logic [NUM_SLAVES-1:0]            we;
    logic [NUM_SLAVES-1:0][DATA_W-1:0] rd_words;

    always_comb begin
        sel_ext = '0;
        sel_ext[NUM_SLAVES-1:0] = bus.sel_en_out;
    end

    assign oh = onehot_idx(sel_ext);

    always_comb begin
        own_mask        = '0;
        own_mask[idx_q] = 1'b1;
    end

    // While waiting, the select must stay exactly the latched slave's bit:
    // losing it or gaining any other bit both abandon the access.
    assign sel_abort = (bus.sel_en_out != own_mask);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ack_d   = '0;
        rd_d    = rd_q;
        we      = '0;
        case (state_q)
            IDLE: begin
                if (oh.valid) begin
                    idx_d   = oh.idx[IDX_W-1:0];
                    wr_d    = bus.wr_rd_d_out;
                    addr_d  = bus.addr_out[MEM_AW-1:0];
                    data_d  = bus.wr_data_out;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES > 0) ? WAIT : ACK;
                end
            end
            WAIT: begin
                if (sel_abort) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q <= CNT_W'(1)) state_d = ACK;
                end
            end
            ACK: begin
                ack_d = own_mask;
                if (wr_q) begin
                    we   = own_mask;
                    rd_d = '0;
                end else begin
                    rd_d = rd_words[idx_q];
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.sel_en_out == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            rd_q    <= rd_d;
        end
    end

    assign bus.ack_in     = ack_q;
    assign bus.rd_data_in = rd_q;

    for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_mem
        slave_mem #(
            .DATA_W   (DATA_W),
            .MEM_DEPTH(MEM_DEPTH),
            .AW       (MEM_AW),
            .SLAVE_ID (s)
        ) u_mem (
            .clock(clock),
            .reset(reset),
            .we   (we[s]),
            .addr (addr_q),
            .wdata(data_q),
            .rdata(rd_words[s])
        );
    end

`ifdef RESP_PROTO_CHECK_EN
    logic [ADDR_W-1:0] addr_full_q;
    logic              proto_q;
    logic              proto_hit;

    // Full address is kept separately because the FSM only latches the
    // wrapped bits, but any change of the driven address is a violation.
    always_comb begin
        proto_hit = 1'b0;
        if (state_q == IDLE && !oh.valid && bus.sel_en_out != '0) proto_hit = 1'b1;
        if (state_q == WAIT) begin
            if (sel_abort) begin
                proto_hit = 1'b1;
            end else if (bus.wr_rd_d_out != wr_q || bus.addr_out != addr_full_q ||
                         bus.wr_data_out != data_q) begin
                proto_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            proto_q     <= 1'b0;
            addr_full_q <= '0;
        end else begin
            if (proto_hit) proto_q <= 1'b1;
            if (state_q == IDLE && oh.valid) addr_full_q <= bus.addr_out;
        end
    end

    assign proto_err = proto_q;
`endif

    // Address bits above the memory index and unused decode bits.
    logic unused_bits;
    assign unused_bits = ^{bus.addr_out[ADDR_W-1:MEM_AW], oh.idx[SEL_IDX_W-1:IDX_W]};

endmodule

// File: tb/tb_unit_slave_responder.sv
module tb_unit_slave_responder;

    logic clock;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    bit   cur_w;   // 1 = dut2 (WAIT_CYCLES=2), 0 = dut0 (WAIT_CYCLES=0)

    logic [7:0] ref_mem [2][6][16];

    unit_slave_responder_if #(.NUM_SLAVES(6), .DATA_W(8), .ADDR_W(8)) bus2 ();
    unit_slave_responder_if #(.NUM_SLAVES(6), .DATA_W(8), .ADDR_W(8)) bus0 ();

`ifdef RESP_PROTO_CHECK_EN
    logic proto2, proto0;
`endif

    unit_slave_responder #(.NUM_SLAVES(6), .DATA_W(8), .ADDR_W(8), .MEM_DEPTH(16), .WAIT_CYCLES(2)) dut (
        .clock(clock),
        .reset(reset),
`ifdef RESP_PROTO_CHECK_EN
        .proto_err(proto2),
`endif
        .bus(bus2)
    );

    unit_slave_responder #(.NUM_SLAVES(6), .DATA_W(8), .ADDR_W(8), .MEM_DEPTH(16), .WAIT_CYCLES(0)) dut0 (
        .clock(clock),
        .reset(reset),
`ifdef RESP_PROTO_CHECK_EN
        .proto_err(proto0),
`endif
        .bus(bus0)
    );

    logic [5:0] ack_mux;
    logic [7:0] rd_mux;
    assign ack_mux = cur_w ? bus2.ack_in : bus0.ack_in;
    assign rd_mux  = cur_w ? bus2.rd_data_in : bus0.rd_data_in;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic ref_init;
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 6; s++)
                for (int a = 0; a < 16; a++)
                    ref_mem[w][s][a] = 8'((s << 4) | a);
    endtask

    task automatic set_bus(input bit w, input logic [5:0] s, input logic wr,
                           input logic [7:0] a, input logic [7:0] d);
        cur_w = w;
        if (w) begin
            bus2.sel_en_out = s; bus2.wr_rd_d_out = wr; bus2.addr_out = a; bus2.wr_data_out = d;
        end else begin
            bus0.sel_en_out = s; bus0.wr_rd_d_out = wr; bus0.addr_out = a; bus0.wr_data_out = d;
        end
    endtask

    // Drives one select for 'hold' cycles, records the first ack (clocks after
    // capture, ack vector, read data) and the number of ack cycles seen.
    task automatic run_txn(input bit w, input int s, input logic wr, input logic [7:0] a,
                           input logic [7:0] d, input int hold, input bit scramble,
                           output int lat, output logic [5:0] ackv, output logic [7:0] rdv,
                           output int nack);
        logic [5:0] sv;
        sv   = 6'(1 << s);
        lat  = -1; ackv = '0; rdv = '0; nack = 0;
        set_bus(w, sv, wr, a, d);
        for (int c = 1; c <= hold; c++) begin
            tick;
            if (scramble && c == 1) set_bus(w, sv, ~wr, a ^ 8'h0F, ~d);
            if (ack_mux !== 6'b0) begin
                nack++;
                if (lat < 0) begin lat = c - 1; ackv = ack_mux; rdv = rd_mux; end
            end
        end
        set_bus(w, 6'b0, 1'b0, 8'h00, 8'h00);
        tick;
        tick;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        set_bus(0, 6'b0, 1'b0, 8'h00, 8'h00);
        set_bus(1, 6'b0, 1'b0, 8'h00, 8'h00);
        tick; tick;
        tests++; if (bus2.ack_in !== 6'b0) begin fails++; $display("FAIL reset_ack2: got %b want 000000", bus2.ack_in); end
        tests++; if (bus2.rd_data_in !== 8'h00) begin fails++; $display("FAIL reset_rd2: got %h want 00", bus2.rd_data_in); end
        tests++; if (bus0.ack_in !== 6'b0) begin fails++; $display("FAIL reset_ack0: got %b want 000000", bus0.ack_in); end
        tests++; if (bus0.rd_data_in !== 8'h00) begin fails++; $display("FAIL reset_rd0: got %h want 00", bus0.rd_data_in); end
`ifdef RESP_PROTO_CHECK_EN
        tests++; if (proto2 !== 1'b0) begin fails++; $display("FAIL reset_proto: got %b want 0", proto2); end
`endif
        reset = 1'b0;
        ref_init;
        tick;
    endtask

    task automatic test_read;
        int lat, nack; logic [5:0] ackv; logic [7:0] rdv;
        run_txn(1, 2, 1'b0, 8'h05, 8'h00, 8, 1'b0, lat, ackv, rdv, nack);
        tests++; if (lat !== 3) begin fails++; $display("FAIL read_latency: got %0d want 3", lat); end
        tests++; if (ackv !== 6'b000100) begin fails++; $display("FAIL read_ack: got %b want 000100", ackv); end
        tests++; if (rdv !== 8'h25) begin fails++; $display("FAIL read_data: got %h want 25", rdv); end
        tests++; if (nack !== 1) begin fails++; $display("FAIL read_ack_cycles: got %0d want 1", nack); end
        tests++; if (bus2.rd_data_in !== 8'h25) begin fails++; $display("FAIL read_data_held: got %h want 25", bus2.rd_data_in); end
`ifdef RESP_PROTO_CHECK_EN
        tests++; if (proto2 !== 1'b0) begin fails++; $display("FAIL read_proto: got %b want 0", proto2); end
`endif
    endtask

    task automatic test_write_readback;
        int lat, nack; logic [5:0] ackv; logic [7:0] rdv;
        run_txn(1, 0, 1'b1, 8'h0A, 8'hC3, 8, 1'b0, lat, ackv, rdv, nack);
        ref_mem[1][0][10] = 8'hC3;
        tests++; if (ackv !== 6'b000001) begin fails++; $display("FAIL wr_ack: got %b want 000001", ackv); end
        tests++; if (rdv !== 8'h00) begin fails++; $display("FAIL wr_rd_zero: got %h want 00", rdv); end
        run_txn(1, 0, 1'b0, 8'h0A, 8'h00, 8, 1'b0, lat, ackv, rdv, nack);
        tests++; if (rdv !== 8'hC3) begin fails++; $display("FAIL wr_readback: got %h want c3", rdv); end
        run_txn(1, 0, 1'b0, 8'h1A, 8'h00, 8, 1'b0, lat, ackv, rdv, nack);
        tests++; if (rdv !== 8'hC3) begin fails++; $display("FAIL wr_wrap_read: got %h want c3", rdv); end
        tests++; if (lat !== 3) begin fails++; $display("FAIL wr_wrap_latency: got %0d want 3", lat); end
    endtask

    task automatic test_hold_wait0;
        int lat, nack; logic [5:0] ackv; logic [7:0] rdv;
        for (int k = 0; k < 2; k++) begin
            run_txn(0, 4, 1'b0, 8'h03, 8'h00, 8, 1'b0, lat, ackv, rdv, nack);
            tests++; if (lat !== 1) begin fails++; $display("FAIL hold_latency[%0d]: got %0d want 1", k, lat); end
            tests++; if (ackv !== 6'b010000) begin fails++; $display("FAIL hold_ack[%0d]: got %b want 010000", k, ackv); end
            tests++; if (rdv !== 8'h43) begin fails++; $display("FAIL hold_data[%0d]: got %h want 43", k, rdv); end
            tests++; if (nack !== 1) begin fails++; $display("FAIL hold_single_ack[%0d]: got %0d want 1", k, nack); end
        end
    endtask

    task automatic test_abort;
        int lat, nack, seen; logic [5:0] ackv; logic [7:0] rdv;
        seen = 0;
        set_bus(1, 6'b100000, 1'b0, 8'h04, 8'h00);
        tick;            // capture
        tick;            // one WAIT cycle
        set_bus(1, 6'b000000, 1'b0, 8'h04, 8'h00);
        for (int c = 0; c < 10; c++) begin tick; if (bus2.ack_in !== 6'b0) seen++; end
        tests++; if (seen !== 0) begin fails++; $display("FAIL abort_drop_ack: got %0d acks want 0", seen); end
`ifdef RESP_PROTO_CHECK_EN
        tests++; if (proto2 !== 1'b1) begin fails++; $display("FAIL abort_proto: got %b want 1", proto2); end
`endif
        // another slave's select rising during WAIT also abandons the access
        seen = 0;
        set_bus(1, 6'b100000, 1'b1, 8'h04, 8'h77);
        tick;
        set_bus(1, 6'b100001, 1'b1, 8'h04, 8'h77);
        for (int c = 0; c < 6; c++) begin tick; if (bus2.ack_in !== 6'b0) seen++; end
        set_bus(1, 6'b000000, 1'b0, 8'h00, 8'h00);
        tick; tick;
        tests++; if (seen !== 0) begin fails++; $display("FAIL abort_other_ack: got %0d acks want 0", seen); end
        run_txn(1, 5, 1'b0, 8'h04, 8'h00, 8, 1'b0, lat, ackv, rdv, nack);
        tests++; if (rdv !== ref_mem[1][5][4]) begin fails++; $display("FAIL abort_mem: got %h want %h", rdv, ref_mem[1][5][4]); end
        tests++; if (lat !== 3) begin fails++; $display("FAIL abort_idle_latency: got %0d want 3", lat); end
    endtask

    task automatic test_multihot;
        int lat, nack, seen; logic [5:0] ackv; logic [7:0] rdv;
        seen = 0;
        set_bus(0, 6'b000011, 1'b0, 8'h01, 8'h00);
        for (int c = 0; c < 10; c++) begin tick; if (bus0.ack_in !== 6'b0) seen++; end
        set_bus(0, 6'b000000, 1'b0, 8'h00, 8'h00);
        tick; tick;
        tests++; if (seen !== 0) begin fails++; $display("FAIL multihot_ack: got %0d acks want 0", seen); end
`ifdef RESP_PROTO_CHECK_EN
        tests++; if (proto0 !== 1'b1) begin fails++; $display("FAIL multihot_proto: got %b want 1", proto0); end
`endif
        run_txn(0, 1, 1'b0, 8'h01, 8'h00, 4, 1'b0, lat, ackv, rdv, nack);
        tests++; if (rdv !== 8'h11) begin fails++; $display("FAIL multihot_after: got %h want 11", rdv); end
`ifdef RESP_PROTO_CHECK_EN
        tests++; if (proto0 !== 1'b1) begin fails++; $display("FAIL multihot_sticky: got %b want 1", proto0); end
`endif
    endtask

    task automatic test_capture_only;
        int lat, nack; logic [5:0] ackv; logic [7:0] rdv;
        run_txn(1, 3, 1'b1, 8'h07, 8'h5A, 8, 1'b1, lat, ackv, rdv, nack);
        ref_mem[1][3][7] = 8'h5A;
        tests++; if (ackv !== 6'b001000) begin fails++; $display("FAIL capture_ack: got %b want 001000", ackv); end
        run_txn(1, 3, 1'b0, 8'h07, 8'h00, 8, 1'b0, lat, ackv, rdv, nack);
        tests++; if (rdv !== 8'h5A) begin fails++; $display("FAIL capture_data: got %h want 5a", rdv); end
        run_txn(1, 3, 1'b0, 8'h08, 8'h00, 8, 1'b0, lat, ackv, rdv, nack);
        tests++; if (rdv !== ref_mem[1][3][8]) begin fails++; $display("FAIL capture_addr: got %h want %h", rdv, ref_mem[1][3][8]); end
    endtask

    task automatic test_random;
        int lat, nack, s; bit w, scr; logic wr; logic [7:0] a, d, exp_rd; logic [5:0] ackv; logic [7:0] rdv;
        for (int n = 0; n < 30; n++) begin
            w   = 1'($urandom_range(0, 1));
            s   = int'($urandom_range(0, 5));
            wr  = 1'($urandom_range(0, 1));
            a   = 8'($urandom);
            d   = 8'($urandom);
            scr = ($urandom_range(0, 3) == 0);
            exp_rd = wr ? 8'h00 : ref_mem[w][s][a[3:0]];
            run_txn(w, s, wr, a, d, 6, scr, lat, ackv, rdv, nack);
            if (wr) ref_mem[w][s][a[3:0]] = d;
            tests++; if (lat !== (w ? 3 : 1)) begin fails++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, lat, w ? 3 : 1); end
            tests++; if (ackv !== 6'(1 << s)) begin fails++; $display("FAIL rnd%0d_ack: got %b want %b", n, ackv, 6'(1 << s)); end
            tests++; if (rdv !== exp_rd) begin fails++; $display("FAIL rnd%0d_data: got %h want %h", n, rdv, exp_rd); end
            tests++; if (nack !== 1) begin fails++; $display("FAIL rnd%0d_ack_cycles: got %0d want 1", n, nack); end
        end
    endtask

    task automatic test_reset_mid;
        int lat, nack; logic [5:0] ackv; logic [7:0] rdv;
        run_txn(1, 3, 1'b0, 8'h01, 8'h00, 6, 1'b0, lat, ackv, rdv, nack);
        tests++; if (rdv !== ref_mem[1][3][1]) begin fails++; $display("FAIL rmid_pre_read: got %h want %h", rdv, ref_mem[1][3][1]); end
        set_bus(1, 6'b000010, 1'b1, 8'h02, 8'hFF);
        tick;            // capture, now waiting
        reset = 1'b1;
        set_bus(1, 6'b000000, 1'b0, 8'h00, 8'h00);
        tick;
        tests++; if (bus2.ack_in !== 6'b0) begin fails++; $display("FAIL rmid_ack: got %b want 000000", bus2.ack_in); end
        tests++; if (bus2.rd_data_in !== 8'h00) begin fails++; $display("FAIL rmid_rd: got %h want 00", bus2.rd_data_in); end
`ifdef RESP_PROTO_CHECK_EN
        tests++; if (proto0 !== 1'b0) begin fails++; $display("FAIL rmid_proto_clear: got %b want 0", proto0); end
`endif
        reset = 1'b0;
        ref_init;
        tick;
        run_txn(1, 1, 1'b0, 8'h02, 8'h00, 6, 1'b0, lat, ackv, rdv, nack);
        tests++; if (rdv !== 8'h12) begin fails++; $display("FAIL rmid_read: got %h want 12", rdv); end
        tests++; if (lat !== 3) begin fails++; $display("FAIL rmid_latency: got %0d want 3", lat); end
    endtask

    initial begin
        reset = 1'b1;
        cur_w = 1'b1;
        ref_init;
        test_reset;
        test_read;
        test_write_readback;
        test_hold_wait0;
        test_abort;
        test_multihot;
        test_capture_only;
        test_random;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
